// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: shift-add multiply, restoring divide, one bit per cycle.
// Optional macro MULDIV_EARLY_OUT_EN ends multiplies once the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       state_dbg
);

  // Handshake: start is taken only while busy is low (IDLE) and flush is low; busy stays
  // high through the whole operation including the valid cycle, and valid is a single-cycle
  // pulse with result already stable. result then holds until the next completed operation.

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic [2:0]         f3_q;
  logic               neg_a_q;
  logic               neg_b_q;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvsr;

  logic               a_signed;
  logic               b_signed;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               div_zero;
  logic               div_ovf;
  logic [WIDTH-1:0]   special_res;
  logic               mul_zero;

  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH-1:0]   mplier_step;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic               mul_last;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   mul_res;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   div_res;

  // Accept-side decode: operand signedness, magnitudes and the divide corner cases.
  always_comb begin
    a_signed    = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_signed    = funct3[2] ? ~funct3[0] : ~funct3[1];
    neg_a       = a_signed & op_a[WIDTH-1];
    neg_b       = b_signed & op_b[WIDTH-1];
    mag_a       = neg_a ? -op_a : op_a;
    mag_b       = neg_b ? -op_b : op_b;
    div_zero    = funct3[2] & (op_b == '0);
    div_ovf     = funct3[2] & ~funct3[0] & (op_a == MIN_INT) & (op_b == '1);
    special_res = '0;
    if (div_zero)
      special_res = funct3[1] ? op_a : '1;
    else if (div_ovf)
      special_res = funct3[1] ? '0 : MIN_INT;
`ifdef MULDIV_EARLY_OUT_EN
    mul_zero    = ~funct3[2] & (mag_b == '0);
`else
    mul_zero    = 1'b0;
`endif
  end

  always_comb begin
    prod_step   = mplier[0] ? prod + mcand : prod;
    mplier_step = mplier >> 1;
    shifted     = {rem, quo[WIDTH-1]};
    diff        = shifted - {1'b0, dvsr};
    ge          = ~diff[WIDTH];
    rem_step    = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step    = {quo[WIDTH-2:0], ge};
`ifdef MULDIV_EARLY_OUT_EN
    mul_last    = (count == LAST) | (mplier_step == '0);
`else
    mul_last    = (count == LAST);
`endif
    prod_fix    = (neg_a_q ^ neg_b_q) ? -prod_step : prod_step;
    mul_res     = (f3_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    quo_fix     = (neg_a_q ^ neg_b_q) ? -quo_step : quo_step;
    rem_fix     = neg_a_q ? -rem_step : rem_step;
    div_res     = f3_q[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      count   <= '0;
      f3_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      prod    <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      result  <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            f3_q    <= funct3;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            count   <= '0;
            prod    <= '0;
            mcand   <= {{WIDTH{1'b0}}, mag_a};
            mplier  <= mag_b;
            rem     <= '0;
            quo     <= mag_a;
            dvsr    <= mag_b;
            if (div_zero | div_ovf) begin
              result <= special_res;
              state  <= S_DONE;
            end else if (mul_zero) begin
              result <= '0;
              state  <= S_DONE;
            end else begin
              state <= funct3[2] ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL: begin
          prod   <= prod_step;
          mcand  <= mcand << 1;
          mplier <= mplier_step;
          if (mul_last) begin
            result <= mul_res;
            state  <= S_DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_DIV: begin
          rem <= rem_step;
          quo <= quo_step;
          if (count == LAST) begin
            result <= div_res;
            state  <= S_DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign valid     = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, corner cases, flush/reset
// behaviour and a random back-to-back run checked through an expected-result queue.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_INT = 32'h8000_0000;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         flush;
  logic [2:0]   funct3;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         valid;
  logic [W-1:0] result;
  logic [1:0]   state_dbg;

  logic [W-1:0] exp_q[$];
  int           checks;
  int           errors;
  logic [W-1:0] last_good;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flush     (flush),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .valid     (valid),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model built on the simulator's own wide arithmetic.
  function automatic logic [W-1:0] model(input logic [2:0] f3, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint       sa, sb, ub;
    logic [63:0]  p;
    logic [W-1:0] r;
    int           ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    r  = '0;
    case (f3)
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: r = (b == 0) ? '1 : ((a == MIN_INT && b == '1) ? MIN_INT : W'(ia / ib));
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: r = (b == 0) ? a : ((a == MIN_INT && b == '1) ? '0 : W'(ia % ib));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Edges from the accepting edge (inclusive) to the edge that raises valid.
  function automatic int exp_lat(input logic [2:0] f3, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    logic [W-1:0] mag;
    int           idx;
    if (f3[2] && (b == 0 || (!f3[0] && a == MIN_INT && b == '1)))
      return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!f3[2]) begin
      mag = (!f3[1] && b[W-1]) ? -b : b;
      if (mag == 0)
        return 1;
      idx = 0;
      for (int i = 0; i < W; i++)
        if (mag[i]) idx = i;
      return idx + 2;
    end
`else
    mag = '0;
    idx = 0;
`endif
    return 33;
  endfunction

  // Driver: called at a negedge; returns at the negedge after the valid cycle.
  task automatic do_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input string name);
    int           edges;
    int           lat;
    logic [W-1:0] e;
    start  = 1'b1;
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    exp_q.push_back(exp);
    lat = exp_lat(f3, a, b);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy: got %b expected 1", name, busy);
    end
    while (valid !== 1'b1 && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: valid not seen within %0d edges", name, edges);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if (result !== e) begin
        errors++;
        $display("FAIL %s result: got %h expected %h", name, result, e);
      end else begin
        last_good = e;
      end
      checks++;
      if (edges != lat) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d", name, edges, lat);
      end
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s pulse: valid %b busy %b expected 0 0", name, valid, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = '0;
    op_a   = '0;
    op_b   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== '0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset: busy %b valid %b result %h state %0d expected 0 0 0 0",
               busy, valid, result, state_dbg);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3");
    do_op(3'b001, MIN_INT, MIN_INT, 32'h4000_0000, "mulh_min");
    do_op(3'b011, MIN_INT, MIN_INT, 32'h4000_0000, "mulhu_min");
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    do_op(3'b000, 32'd1000, 32'd3, 32'd3000, "mul_1000x3");
    do_op(3'b000, 32'd12345, 32'd0, 32'd0, "mul_by_zero");
  endtask

  task automatic test_div();
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_-7/2");
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_-7/2");
    do_op(3'b101, 32'd100, 32'd7, 32'd14, "divu_100/7");
    do_op(3'b111, 32'd100, 32'd7, 32'd2, "remu_100/7");
  endtask

  task automatic test_special();
    do_op(3'b100, 32'd55, 32'd0, 32'hFFFF_FFFF, "div_by_zero");
    do_op(3'b101, 32'd55, 32'd0, 32'hFFFF_FFFF, "divu_by_zero");
    do_op(3'b110, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, "rem_by_zero");
    do_op(3'b111, 32'd5, 32'd0, 32'd5, "remu_by_zero");
    do_op(3'b100, MIN_INT, 32'hFFFF_FFFF, MIN_INT, "div_overflow");
    do_op(3'b110, MIN_INT, 32'hFFFF_FFFF, 32'd0, "rem_overflow");
  endtask

  task automatic test_start_ignored();
    int           edges;
    logic [W-1:0] e;
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'd100;
    op_b   = 32'd7;
    exp_q.push_back(32'd14);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    while (valid !== 1'b1 && edges < 200) begin
      if (edges == 5) begin
        start  = 1'b1;
        funct3 = 3'b000;
        op_a   = 32'd3;
        op_b   = 32'd5;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0;
    end
    e = exp_q.pop_front();
    checks++;
    if (valid !== 1'b1 || result !== e) begin
      errors++;
      $display("FAIL start_ignored result: valid %b got %h expected %h", valid, result, e);
    end else begin
      last_good = e;
    end
    checks++;
    if (edges != 33) begin
      errors++;
      $display("FAIL start_ignored latency: got %0d expected 33", edges);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored idle: busy %b expected 0", busy);
    end
  endtask

  task automatic test_flush();
    int seen;
    int edges;
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b100;
    op_a   = 32'd1000;
    op_b   = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: busy %b expected 0", busy);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || result !== last_good) begin
      errors++;
      $display("FAIL flush_kill: valid cycles %0d result %h expected 0 and %h",
               seen, result, last_good);
    end
    // flush together with start in IDLE must not launch an operation
    start  = 1'b1;
    flush  = 1'b1;
    funct3 = 3'b000;
    op_a   = 32'd9;
    op_b   = 32'd9;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || result !== last_good) begin
      errors++;
      $display("FAIL flush_start: busy %b result %h expected 0 and %h", busy, result, last_good);
    end
    // flush landing in the valid cycle ends it; the result written on DONE entry stays
    start  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'd20;
    op_b   = 32'd6;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    while (valid !== 1'b1 && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || result !== 32'd3) begin
      errors++;
      $display("FAIL flush_done: valid %b busy %b result %h expected 0 0 %h",
               valid, busy, result, 32'd3);
    end
    last_good = 32'd3;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b000;
    op_a   = 32'd7;
    op_b   = 32'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy %b valid %b result %h expected 0 0 0", busy, valid, result);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [2:0]   f3;
    logic [W-1:0] a;
    logic [W-1:0] b;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: a = MIN_INT;
        1: a = '1;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: b = '0;
        1: b = '1;
        2: b = 32'($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      do_op(f3, a, b, model(f3, a, b), "random");
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_good = '0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_start_ignored();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
